// File: rtl/restoring_divider_pkg.sv
// rtl/restoring_divider_pkg.sv - shared FSM encoding and default width for the divider
package restoring_divider_pkg;

  localparam int DIV_WIDTH_DEFAULT = 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_e;

  // Counter wide enough to hold WIDTH-1, never narrower than one bit.
  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/restoring_divider_if.sv
// rtl/restoring_divider_if.sv - start/ready/done handshake between FPU sequencer and divider
interface restoring_divider_if
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
);

  logic             start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             ready;
  logic             done;
  logic [WIDTH-1:0] Q;
  logic [WIDTH-1:0] R;
  logic             div_by_zero;

  modport master (
    output start, A, B,
    input  ready, done, Q, R, div_by_zero
  );

  modport slave (
    input  start, A, B,
    output ready, done, Q, R, div_by_zero
  );

endinterface

// File: rtl/restoring_divider_div_step.sv
// rtl/restoring_divider_div_step.sv - one combinational restoring-division iteration
module restoring_divider_div_step #(
  parameter int WIDTH = 8
) (
  input  logic [WIDTH:0]   rem_i,
  input  logic             q_msb_i,
  input  logic [WIDTH-1:0] divisor_i,
  output logic [WIDTH:0]   rem_o,
  output logic             q_bit_o
);

  logic [WIDTH:0] shifted;
  logic [WIDTH:0] diff;
  logic           unused_rem_msb;

  // The partial remainder stays below the divisor, so its top bit is always shifted out.
  assign unused_rem_msb = rem_i[WIDTH];

  assign shifted = {rem_i[WIDTH-1:0], q_msb_i};
  assign diff    = shifted - {1'b0, divisor_i};
  assign q_bit_o = (shifted >= {1'b0, divisor_i});
  assign rem_o   = q_bit_o ? diff : shifted;

endmodule

// File: rtl/restoring_divider.sv
// rtl/restoring_divider.sv - iterative radix-2 restoring unsigned divider, one quotient bit per clock
module restoring_divider
  import restoring_divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH_DEFAULT
) (
  input  logic                clk,
  input  logic                rst,
  restoring_divider_if.slave  bus
);

  localparam int CNT_W = cnt_width(WIDTH);

  div_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] divisor_q, divisor_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH:0]   rem_q, rem_d;
  logic [WIDTH-1:0] q_out_q, q_out_d;
  logic [WIDTH-1:0] r_out_q, r_out_d;
  logic             dbz_q, dbz_d;

  logic [WIDTH:0]   rem_next;
  logic             q_bit;

  restoring_divider_div_step #(.WIDTH(WIDTH)) u_step (
    .rem_i     (rem_q),
    .q_msb_i   (quo_q[WIDTH-1]),
    .divisor_i (divisor_q),
    .rem_o     (rem_next),
    .q_bit_o   (q_bit)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      divisor_q <= '0;
      quo_q     <= '0;
      rem_q     <= '0;
      q_out_q   <= '0;
      r_out_q   <= '0;
      dbz_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      divisor_q <= divisor_d;
      quo_q     <= quo_d;
      rem_q     <= rem_d;
      q_out_q   <= q_out_d;
      r_out_q   <= r_out_d;
      dbz_q     <= dbz_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    divisor_d = divisor_q;
    quo_d     = quo_q;
    rem_d     = rem_q;
    q_out_d   = q_out_q;
    r_out_d   = r_out_q;
    dbz_d     = dbz_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.start) begin
          divisor_d = bus.B;
          quo_d     = bus.A;
          rem_d     = '0;
          cnt_d     = CNT_W'(WIDTH - 1);
          dbz_d     = 1'b0;
          if (bus.B == '0) begin
            // Divide-by-zero skips iteration and publishes the saturated result directly.
            state_d = ST_DONE;
            q_out_d = '1;
            r_out_d = bus.A;
            dbz_d   = 1'b1;
          end else begin
            state_d = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        quo_d = {quo_q[WIDTH-2:0], q_bit};
        rem_d = rem_next;
        if (cnt_q == '0) begin
          state_d = ST_DONE;
          q_out_d = {quo_q[WIDTH-2:0], q_bit};
          r_out_d = rem_next[WIDTH-1:0];
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  assign bus.ready       = (state_q == ST_IDLE);
  assign bus.done        = (state_q == ST_DONE);
  assign bus.Q           = q_out_q;
  assign bus.R           = r_out_q;
  assign bus.div_by_zero = dbz_q;

endmodule

// File: tb/tb_restoring_divider.sv
// tb/tb_restoring_divider.sv - scoreboard bench for restoring_divider with directed vectors
module tb_restoring_divider;

  typedef struct {
    logic [7:0] a;
    logic [7:0] b;
    logic [7:0] q;
    logic [7:0] r;
    logic       dbz;
  } exp_t;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  exp_t sb[$];

  restoring_divider_if #(.WIDTH(8)) bus ();

  restoring_divider #(.WIDTH(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference 8x8 product built from three 4-bit partial products.
  function automatic logic [15:0] kmul8(input logic [7:0] x, input logic [7:0] y);
    logic [7:0]  z2, z0;
    logic [9:0]  z1;
    logic [4:0]  sx, sy;
    z2 = {4'b0, x[7:4]} * {4'b0, y[7:4]};
    z0 = {4'b0, x[3:0]} * {4'b0, y[3:0]};
    sx = {1'b0, x[7:4]} + {1'b0, x[3:0]};
    sy = {1'b0, y[7:4]} + {1'b0, y[3:0]};
    z1 = {5'b0, sx} * {5'b0, sy} - {2'b0, z2} - {2'b0, z0};
    return {z2, 8'h00} + ({6'b0, z1} << 4) + {8'h00, z0};
  endfunction

  always @(negedge clk) begin
    if (!rst && bus.done) begin
      if (sb.size() == 0) begin
        check("unexpected_done", 32'(bus.done), 32'(0));
      end else begin
        exp_t e;
        e = sb.pop_front();
        check("Q", 32'(bus.Q), 32'(e.q));
        check("R", 32'(bus.R), 32'(e.r));
        check("div_by_zero", 32'(bus.div_by_zero), 32'(e.dbz));
        if (!e.dbz) begin
          check("QxB_plus_R", 32'(kmul8(bus.Q, e.b) + {8'h00, bus.R}), 32'(e.a));
          check("R_lt_B", 32'(bus.R < e.b), 32'(1));
        end
      end
    end
  end

  task automatic wait_ready();
    int n;
    n = 0;
    while (!bus.ready && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (!bus.ready) check("ready_timeout", 32'(bus.ready), 32'(1));
  endtask

  // Called at a negedge; inj>0 re-pulses start with 9/2 during that cycle of the run.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] q,
                       input logic [7:0] r, input logic dbz, input int exp_lat, input int inj);
    int   n;
    exp_t e;
    wait_ready();
    bus.start = 1'b1;
    bus.A     = a;
    bus.B     = b;
    e.a = a; e.b = b; e.q = q; e.r = r; e.dbz = dbz;
    sb.push_back(e);
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    bus.A     = 8'($urandom());
    bus.B     = 8'($urandom());
    n = 0;
    do begin
      @(negedge clk);
      n++;
      if (n == inj) begin
        bus.start = 1'b1;
        bus.A     = 8'd9;
        bus.B     = 8'd2;
      end else begin
        bus.start = 1'b0;
      end
    end while (!bus.done && n < 40);
    check("done_latency", 32'(n), 32'(exp_lat));
    @(negedge clk);
    check("ready_after_done", 32'(bus.ready), 32'(1));
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, %0d checks, %0d errors", checks, errors);
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [7:0] ra, rb;
    checks    = 0;
    errors    = 0;
    rst       = 1'b1;
    bus.start = 1'b0;
    bus.A     = '0;
    bus.B     = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", 32'(bus.ready), 32'(1));
    check("reset_done", 32'(bus.done), 32'(0));
    check("reset_Q", 32'(bus.Q), 32'(0));
    check("reset_R", 32'(bus.R), 32'(0));
    check("reset_dbz", 32'(bus.div_by_zero), 32'(0));

    do_op(8'd200, 8'd7,   8'd28,  8'd4,   1'b0, 9, 0);
    do_op(8'd255, 8'd1,   8'd255, 8'd0,   1'b0, 9, 0);
    do_op(8'd5,   8'd9,   8'd0,   8'd5,   1'b0, 9, 0);
    do_op(8'd255, 8'd255, 8'd1,   8'd0,   1'b0, 9, 0);
    do_op(8'd77,  8'd0,   8'd255, 8'd77,  1'b1, 1, 0);
    do_op(8'd0,   8'd13,  8'd0,   8'd0,   1'b0, 9, 0);
    do_op(8'd128, 8'd16,  8'd8,   8'd0,   1'b0, 9, 0);
    do_op(8'd254, 8'd255, 8'd0,   8'd254, 1'b0, 9, 0);
    do_op(8'd100, 8'd3,   8'd33,  8'd1,   1'b0, 9, 4);

    // Abort a running divide with reset; no done may follow.
    wait_ready();
    bus.start = 1'b1;
    bus.A     = 8'd200;
    bus.B     = 8'd7;
    @(posedge clk);
    #1;
    bus.start = 1'b0;
    n = 0;
    while (n < 5) begin
      @(negedge clk);
      n++;
    end
    #2;
    rst = 1'b1;
    #1;
    check("rst_Q", 32'(bus.Q), 32'(0));
    check("rst_R", 32'(bus.R), 32'(0));
    check("rst_done", 32'(bus.done), 32'(0));
    check("rst_ready", 32'(bus.ready), 32'(1));
    check("rst_dbz", 32'(bus.div_by_zero), 32'(0));
    repeat (2) @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    do_op(8'd50, 8'd6, 8'd8, 8'd2, 1'b0, 9, 0);

    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom());
      rb = 8'($urandom_range(1, 255));
      do_op(ra, rb, ra / rb, ra % rb, 1'b0, 9, 0);
    end

    repeat (5) @(negedge clk);
    check("scoreboard_empty", 32'(sb.size()), 32'(0));
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
